// File: rtl/ece571f23_g5_aes_pkg.sv
// Shared AES types, SubBytes FSM encoding and GF(2^8) S-box helpers.
// Inverse helpers are only referenced when AES_SUBBYTES_INV_EN is defined.
package ece571f23_g5_aes_pkg;

  localparam int AES_STATE_BYTES = 16;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } subbytes_state_e;

  function automatic aes_byte_t gf_mul(aes_byte_t a, aes_byte_t b);
    aes_byte_t p;
    aes_byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; 0 maps to 0
  function automatic aes_byte_t gf_inv(aes_byte_t a);
    aes_byte_t r;
    aes_byte_t s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic aes_byte_t sbox_fwd(aes_byte_t a);
    aes_byte_t b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic aes_byte_t sbox_inv(aes_byte_t a);
    aes_byte_t b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]}
      ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

endpackage

// File: rtl/ece571f23_g5_aes_inv_sbox.sv
// Inverse AES S-box, purely combinational.
// Only built when AES_SUBBYTES_INV_EN is defined.
`ifdef AES_SUBBYTES_INV_EN
module ece571f23_g5_aes_inv_sbox
  import ece571f23_g5_aes_pkg::*;
(
  output aes_byte_t out,
  input  aes_byte_t in
);

  assign out = sbox_inv(in);

endmodule
`endif

// File: rtl/ece571f23_g5_aes_sbox.sv
// Forward AES S-box, purely combinational.
module ece571f23_g5_aes_sbox
  import ece571f23_g5_aes_pkg::*;
(
  output aes_byte_t out,
  input  aes_byte_t in
);

  assign out = sbox_fwd(in);

endmodule

// File: rtl/ece571f23_g5_aes_subbytes_seq.sv
// Sequential SubBytes engine: LANES bytes per cycle, in-place on a work reg.
// AES_SUBBYTES_INV_EN adds per-lane inverse S-boxes selected by in_inverse.
module ece571f23_g5_aes_subbytes_seq
  import ece571f23_g5_aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inverse,
  input  logic [127:0] datain,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dataout,
  output logic         busy
);

  localparam int BEATS = AES_STATE_BYTES / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
        LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $fatal(1, "LANES must be 1, 2, 4, 8 or 16");
  end

  subbytes_state_e state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  aes_state_t      work_q, work_d;

  aes_byte_t lane_in  [LANES];
  aes_byte_t fwd_out  [LANES];
  aes_byte_t lane_out [LANES];

`ifdef AES_SUBBYTES_INV_EN
  logic      inv_q, inv_d;
  aes_byte_t inv_out [LANES];
`else
  logic unused_in_inverse;
  assign unused_in_inverse = in_inverse;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] =
      work_q[8*(int'(beat_q)*LANES + l) +: 8];

    ece571f23_g5_aes_sbox u_sbox (
      .out (fwd_out[l]),
      .in  (lane_in[l])
    );

`ifdef AES_SUBBYTES_INV_EN
    ece571f23_g5_aes_inv_sbox u_inv_sbox (
      .out (inv_out[l]),
      .in  (lane_in[l])
    );
    assign lane_out[l] = inv_q ? inv_out[l] : fwd_out[l];
`else
    assign lane_out[l] = fwd_out[l];
`endif
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    work_d  = work_q;
`ifdef AES_SUBBYTES_INV_EN
    inv_d   = inv_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          work_d  = datain;
          beat_d  = '0;
`ifdef AES_SUBBYTES_INV_EN
          inv_d   = in_inverse;
`endif
        end
      end
      RUN: begin
        // write back only the bytes owned by the current beat
        for (int b = 0; b < AES_STATE_BYTES; b++) begin
          if (BW'(b / LANES) == beat_q)
            work_d[8*b +: 8] = lane_out[b % LANES];
        end
        if (beat_q == BW'(BEATS - 1)) state_d = DONE;
        else beat_d = beat_q + 1'b1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      work_q  <= '0;
`ifdef AES_SUBBYTES_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      work_q  <= work_d;
`ifdef AES_SUBBYTES_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign dataout   = work_q;

endmodule

// File: tb/tb_ece571f23_g5_aes_subbytes_seq.sv
// Scoreboard bench for the sequential SubBytes engine (LANES=4 main DUT
// plus latency/vector probes for LANES=1,2,8,16).
module tb_ece571f23_g5_aes_subbytes_seq;
  import ece571f23_g5_aes_pkg::*;

  localparam int ML    = 4;
  localparam int MBEAT = 16 / ML;
`ifdef AES_SUBBYTES_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam aes_state_t APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam aes_state_t APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam aes_state_t ALL63    = {16{8'h63}};

  logic       clk = 1'b0;
  logic       rst, rst_g;
  logic       in_valid, in_ready, in_inverse;
  aes_state_t datain, dataout;
  logic       out_valid, out_ready, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gen_done = 0;
  bit rand_or = 1'b0;

  typedef struct {
    aes_state_t data;
    int         acc;
  } exp_t;
  exp_t sbq[$];

  logic [7:0] sb [256];
  logic [7:0] isb[256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ece571f23_g5_aes_subbytes_seq #(.LANES(ML)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inverse (in_inverse),
    .datain     (datain),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dataout    (dataout),
    .busy       (busy)
  );

  // Reference S-box from the generator-3 exp/log tables and bitwise affine map
  function automatic logic [7:0] xt(logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_tables();
    logic [7:0] ex[256];
    int         lg[256];
    logic [7:0] p, iv, o, c;
    p = 8'h01;
    c = 8'h63;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = i;
      p = p ^ xt(p);
    end
    for (int x = 0; x < 256; x++) begin
      iv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int i = 0; i < 8; i++)
        o[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8]
             ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ c[i];
      sb[x]  = o;
      isb[o] = 8'(x);
    end
  endtask

  function automatic aes_state_t ref_sub(aes_state_t d, logic inv);
    aes_state_t r;
    for (int k = 0; k < 16; k++)
      r[8*k +: 8] = (inv && INV_EN) ? isb[d[8*k +: 8]] : sb[d[8*k +: 8]];
    return r;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Called at posedge+2; returns with the block accepted (or timed out)
  task automatic send(input aes_state_t d, input logic inv,
                      input aes_state_t exp, output int acc);
    int g;
    g = 0;
    acc = -1;
    in_valid = 1'b1;
    datain = d;
    in_inverse = inv;
    while (!in_ready && g < 200) begin
      @(posedge clk); #2;
      g++;
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
    end else begin
      acc = cyc;
      sbq.push_back('{data: exp, acc: cyc});
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    in_inverse = 1'($urandom);
    datain = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain_left", 128'(sbq.size()), 0);
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    chk("wait_out_valid", out_valid, 1);
  endtask

  // Monitor: latency on rise, data on handshake, stability while stalled
  logic       prev_ov = 1'b0;
  logic       prev_hs = 1'b0;
  aes_state_t prev_do;
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_ov && !prev_hs) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", dataout, prev_do);
        chk("hold_in_ready", in_ready, 0);
      end
      if (out_valid && !prev_ov) begin
        if (sbq.size() == 0) chk("unexpected_out", 1, 0);
        else chk("latency", 128'(cyc - sbq[0].acc), 128'(MBEAT + 1));
      end
      if (out_valid && out_ready && sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("dataout", dataout, e.data);
      end
      prev_ov = out_valid;
      prev_hs = out_valid && out_ready;
      prev_do = dataout;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      if (rand_or) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Latency / vector probes for the other lane counts
  localparam int GL[4] = '{1, 2, 8, 16};
  for (genvar g = 0; g < 4; g++) begin : g_lat
    localparam int L = GL[g];
    logic       gv, grdy, gov, gbz;
    aes_state_t gin, gdout;

    ece571f23_g5_aes_subbytes_seq #(.LANES(L)) u_dut (
      .clk        (clk),
      .rst        (rst_g),
      .in_valid   (gv),
      .in_ready   (grdy),
      .in_inverse (1'b0),
      .datain     (gin),
      .out_valid  (gov),
      .out_ready  (1'b1),
      .dataout    (gdout),
      .busy       (gbz)
    );

    initial begin
      int n;
      gv = 1'b0;
      gin = APPB_IN;
      @(negedge rst_g);
      @(posedge clk); #2;
      chk($sformatf("L%0d_ready", L), grdy, 1);
      gv = 1'b1;
      n = 0;
      do begin
        @(posedge clk); #2;
        gv = 1'b0;
        gin = '0;
        n++;
      end while (!gov && n < 40);
      chk($sformatf("L%0d_latency", L), 128'(n), 128'(16 / L + 1));
      chk($sformatf("L%0d_data", L), gdout, APPB_OUT);
      gen_done++;
    end
  end

  initial begin
    int a1, a2, n;
    aes_state_t r;
    logic ri;
    rst = 1'b1;
    rst_g = 1'b1;
    in_valid = 1'b0;
    in_inverse = 1'b0;
    out_ready = 1'b1;
    datain = '0;
    build_tables();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    rst_g = 1'b0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dataout", dataout, 0);

    send('0, 1'b0, ALL63, a1);
    drain();
    send(APPB_IN, 1'b0, APPB_OUT, a1);
    drain();
    chk("idle_holds_result", dataout, APPB_OUT);
    send(APPB_OUT, 1'b1, INV_EN ? APPB_IN : ref_sub(APPB_OUT, 1'b0), a1);
    drain();

    // Backpressure with a second request waiting
    out_ready = 1'b0;
    send(APPB_IN, 1'b0, APPB_OUT, a1);
    wait_ov();
    r = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    datain = r;
    repeat (10) begin
      @(posedge clk); #2;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_idle_data", dataout, APPB_OUT);
    send(r, 1'b0, ref_sub(r, 1'b0), a1);
    drain();

    // Abort mid-RUN at beat 2
    r = {$urandom, $urandom, $urandom, $urandom};
    send(r, 1'b0, ref_sub(r, 1'b0), a1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    sbq.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_data", dataout, 0);
    r = {$urandom, $urandom, $urandom, $urandom};
    send(r, 1'b0, ref_sub(r, 1'b0), a1);
    drain();

    // Back-to-back initiation interval
    r = {$urandom, $urandom, $urandom, $urandom};
    send(r, 1'b0, ref_sub(r, 1'b0), a1);
    r = {$urandom, $urandom, $urandom, $urandom};
    send(r, 1'b1, ref_sub(r, 1'b1), a2);
    chk("b2b_interval", 128'(a2 - a1), 128'(MBEAT + 2));
    drain();

    rand_or = 1'b1;
    repeat (20) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      ri = 1'($urandom);
      send(r, ri, ref_sub(r, ri), a1);
    end
    rand_or = 1'b0;
    out_ready = 1'b1;
    drain();

    n = 0;
    while (gen_done < 4 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk("probes_done", 128'(gen_done), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
